counter_seq_ctrl: RTL and testbench

//   Command-driven sequencer for the N-bit up/down counter with parallel load.

---
 rtl/counter_seq_ctrl.sv | 87 ++++++++
 tb/tb_counter_seq_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: command-driven sequencer for an N-bit up/down counter with parallel load
module counter_seq_ctrl #(
    parameter int N = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [N-1:0] cmd_arg,
    input  logic         abort,
    input  logic [N-1:0] cnt_in,
    output logic         ctr_load,
    output logic         ctr_en,
    output logic         ctr_d,
    output logic [N-1:0] ctr_value,
    output logic         busy,
    output logic         done,
    output logic         wrap
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_WAIT, S_DONE} state_t;
    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_DOWN = 2'd2;
    localparam logic [1:0] OP_WAIT = 2'd3;
    state_t       state_q, state_d;
    logic [1:0]   op_q, op_d;
    logic [N-1:0] arg_q, arg_d;
    logic [N-1:0] remaining_q, remaining_d;
    logic         wrap_q, wrap_d;
    logic         accept, killed, down, run_step, at_edge;
    assign accept   = cmd_valid & cmd_ready;
    assign killed   = abort & (state_q != S_IDLE);
    assign down     = op_q == OP_DOWN;
    assign run_step = (state_q == S_RUN) & ~abort;
    assign at_edge  = down ? (cnt_in == '0) : (cnt_in == {N{1'b1}});
    // state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            arg_q       <= '0;
            remaining_q <= '0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            arg_q       <= arg_d;
            remaining_q <= remaining_d;
            wrap_q      <= wrap_d;
        end
    end
    // next state: zero-length non-LOAD commands go straight to DONE; abort wins everywhere but IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (accept) state_d = (cmd_op == OP_LOAD) ? S_LOAD :
                                          (cmd_arg == '0)     ? S_DONE :
                                          (cmd_op == OP_WAIT) ? S_WAIT : S_RUN;
            S_LOAD: state_d = S_DONE;
            S_RUN, S_WAIT: state_d = (remaining_q == N'(1)) ? S_DONE : state_q;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (killed) state_d = S_IDLE;
    end
    // command capture, cycle countdown and sticky wrap detection on each real counter step
    always_comb begin
        op_d        = accept ? cmd_op : op_q;
        arg_d       = accept ? cmd_arg : arg_q;
        remaining_d = accept ? cmd_arg :
                      ((state_q == S_RUN || state_q == S_WAIT) && remaining_q != '0) ? remaining_q - N'(1) :
                      remaining_q;
        if (killed) remaining_d = '0;
        wrap_d = accept ? 1'b0 : (wrap_q | (run_step & at_edge));
    end
    // Moore outputs from registered state, forced low in reset and gated by abort where it must act at once
    always_comb begin
        cmd_ready = ~rst & (state_q == S_IDLE);
        ctr_load  = ~rst & ~abort & (state_q == S_LOAD);
        ctr_en    = ~rst & run_step;
        ctr_d     = ~rst & (state_q == S_RUN) & down;
        ctr_value = (~rst && state_q == S_LOAD) ? arg_q : '0;
        busy      = ~rst & (state_q != S_IDLE);
        done      = ~rst & ~abort & (state_q == S_DONE);
        wrap      = wrap_q;
    end
endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb_counter_seq_ctrl: scoreboard bench driving the sequencer against a behavioural counter
module tb_counter_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [10:0] cmd_arg = '0;
    logic        abort = 1'b0;
    logic [10:0] cnt_in = '0;
    logic        ctr_load, ctr_en, ctr_d, busy, done, wrap;
    logic [10:0] ctr_value;
    int          cyc = 0;
    int          en_cnt = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          mv = 0;
    int          acc1, acc2;
    typedef struct {
        int exp_cyc;
        int exp_cnt;
        bit exp_wrap;
        int exp_en;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    counter_seq_ctrl #(.N(11)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .abort(abort), .cnt_in(cnt_in),
        .ctr_load(ctr_load), .ctr_en(ctr_en), .ctr_d(ctr_d), .ctr_value(ctr_value),
        .busy(busy), .done(done), .wrap(wrap)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // the counter being controlled: no reset, wraps modulo 2^11
    always @(posedge clk) begin
        if (ctr_load) cnt_in <= ctr_value;
        else if (ctr_en) cnt_in <= ctr_d ? cnt_in - 11'd1 : cnt_in + 11'd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (ctr_en) en_cnt++;
        if (done) begin
            if (sb.size() == 0) check("unexpected_done", 1, 0);
            else begin
                e = sb.pop_front();
                check("done_cyc", cyc, e.exp_cyc);
                check("cnt_in", cnt_in, e.exp_cnt);
                check("wrap", wrap, e.exp_wrap);
                check("en_cycles", en_cnt, e.exp_en);
            end
        end
    end

    task automatic send(input logic [1:0] op, input int arg, input bit push, input bit hold, output int acc);
        int k, lat, en, nv;
        bit w;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_arg = arg[10:0];
        #1;
        k = 0;
        while (!cmd_ready && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        acc = cyc;
        if (!cmd_ready) check("accept_timeout", 0, 1);
        en_cnt = 0;
        nv = mv;
        w = 0;
        en = 0;
        if (op == 2'd0) begin
            nv = arg;
            lat = 2;
        end else if (arg == 0) lat = 1;
        else begin
            lat = arg + 1;
            if (op == 2'd1) begin
                w = (mv + arg) > 2047;
                nv = (mv + arg) % 2048;
                en = arg;
            end else if (op == 2'd2) begin
                w = arg > mv;
                nv = (mv - arg + 2048) % 2048;
                en = arg;
            end
        end
        if (push) begin
            mv = nv;
            sb.push_back('{acc + lat, nv, w, en});
        end
        @(posedge clk);
        #1;
        if (!hold) cmd_valid = 1'b0;
    endtask

    initial begin
        int a;
        repeat (2) begin
            @(negedge clk);
            #1;
            check("rst_outs", {ctr_load, ctr_en, ctr_d, ctr_value, busy, done, cmd_ready}, 0);
        end
        rst = 1'b0;
        #1;
        check("ready_after_rst", cmd_ready, 1);
        check("busy_after_rst", busy, 0);
        check("wrap_after_rst", wrap, 0);
        send(2'd0, 5, 1, 0, a);
        send(2'd1, 3, 1, 0, a);
        send(2'd0, 2046, 1, 0, a);
        send(2'd1, 3, 1, 0, a);
        send(2'd2, 2, 1, 0, a);
        send(2'd0, 5, 1, 0, a);
        send(2'd1, 0, 1, 0, a);
        send(2'd3, 0, 1, 0, a);
        send(2'd0, 100, 1, 0, a);
        send(2'd1, 10, 0, 0, a);
        repeat (4) @(negedge clk);
        abort = 1'b1;
        #1;
        check("abort_en_gate", ctr_en, 0);
        check("abort_load_gate", ctr_load, 0);
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_ready", cmd_ready, 1);
        check("abort_busy", busy, 0);
        mv = mv + 3;
        check("abort_cnt", cnt_in, mv);
        check("abort_wrap", wrap, 0);
        send(2'd3, 4, 1, 1, acc1);
        send(2'd0, 7, 1, 0, acc2);
        check("wait_next_accept", acc2 - acc1, 6);
        send(2'd1, 20, 0, 0, a);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_outs", {ctr_load, ctr_en, ctr_d, ctr_value, busy, done, cmd_ready}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_ready", cmd_ready, 1);
        check("midrst_cnt", cnt_in, mv);
        send(2'd2, 8, 1, 0, a);
        send(2'd1, 1, 1, 0, a);
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        check("sb_drain", sb.size(), 0);
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
